// File: rtl/horner_seq_ctrl_pkg.sv
// Shared types and defaults for the Horner sequencer slice.
package horner_seq_ctrl_pkg;

    localparam int unsigned DEGREE_DEF   = 3;
    localparam int unsigned LOOP_LAT_DEF = 1;
    localparam int unsigned COEFF_W_DEF  = 32;
    localparam int unsigned XLIN_W_DEF   = 21;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_STEP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Index width that never collapses to zero bits.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/horner_seq_ctrl_if.sv
// Link between the sequencer (master) and the hornerLoop datapath (slave).
interface horner_seq_ctrl_if
    import horner_seq_ctrl_pkg::*;
#(
    parameter int unsigned COEFF_W = COEFF_W_DEF,
    parameter int unsigned XLIN_W  = XLIN_W_DEF
);
    logic [COEFF_W-1:0] x_smc;
    logic [COEFF_W-1:0] coeff;
    logic               sum_en;
    logic               sum_rst;
    logic [XLIN_W-1:0]  x_lin;

    modport master (output x_smc, coeff, sum_en, sum_rst, input  x_lin);
    modport slave  (input  x_smc, coeff, sum_en, sum_rst, output x_lin);
endinterface

// File: rtl/horner_seq_ctrl_coeff_rf.sv
// Coefficient register file: one gated synchronous write port, one combinational read port.
module horner_seq_ctrl_coeff_rf #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_c
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = (wr_en_i && (wr_addr_i == ADDR_W'(i))) ? wr_data_i : mem_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Decoded read keeps out-of-range addresses from indexing past the array.
    always_comb begin
        rd_data_c = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (rd_addr_i == ADDR_W'(i)) rd_data_c = mem_q[i];
        end
    end
endmodule

// File: rtl/horner_seq_ctrl.sv
// Sequencer driving hornerLoop: latch a sample, clear, feed coefficients high order first, capture result.
module horner_seq_ctrl
    import horner_seq_ctrl_pkg::*;
#(
    parameter  int unsigned DEGREE   = DEGREE_DEF,
    parameter  int unsigned LOOP_LAT = LOOP_LAT_DEF,
    parameter  int unsigned COEFF_W  = COEFF_W_DEF,
    parameter  int unsigned XLIN_W   = XLIN_W_DEF,
    localparam int unsigned K_W      = width_of(DEGREE + 1)
) (
    input  logic               Clock,
    input  logic               GlobalReset,
    input  logic [COEFF_W-1:0] x_adc_smc_i,
    input  logic               srdyi_i,
    input  logic               coeff_wr_i,
    input  logic [K_W-1:0]     coeff_addr_i,
    input  logic [COEFF_W-1:0] coeff_data_i,
    horner_seq_ctrl_if.master  loop_if,
    output logic [XLIN_W-1:0]  y_o,
    output logic               srdyo_o,
    output logic               busy_o,
    output logic               drop_o
);
    localparam int unsigned CNT_W = width_of(LOOP_LAT);

    state_e             state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COEFF_W-1:0] x_smc_q, x_smc_d;
    logic [COEFF_W-1:0] coeff_q, coeff_d;
    logic               sum_en_q, sum_en_d;
    logic               sum_rst_q, sum_rst_d;
    logic [XLIN_W-1:0]  y_q, y_d;
    logic               srdyo_q, srdyo_d;
    logic               busy_q, busy_d;
    logic               drop_q, drop_d;
    logic               accept_c;
    logic               step_last_c;
    logic               coeff_we_c;
    logic [COEFF_W-1:0] rf_rd_c;

    // Next state, step index and per-step cycle counter.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        accept_c    = 1'b0;
        step_last_c = (cnt_q == CNT_W'(LOOP_LAT - 1));
        case (state_q)
            ST_IDLE: begin
                if (srdyi_i) begin
                    accept_c = 1'b1;
                    state_d  = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                k_d     = K_W'(DEGREE);
                cnt_d   = '0;
                state_d = ST_STEP;
            end
            ST_STEP: begin
                if (step_last_c) begin
                    cnt_d = '0;
                    if (k_q == '0) state_d = ST_DRAIN;
                    else           k_d     = k_q - K_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (step_last_c) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (srdyi_i) begin
                    accept_c = 1'b1;
                    state_d  = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the upcoming state so they line up with it.
    always_comb begin
        coeff_we_c = coeff_wr_i
                   && ((state_q == ST_IDLE) || (state_q == ST_DONE))
                   && ({1'b0, coeff_addr_i} <= (K_W + 1)'(DEGREE));
        x_smc_d    = accept_c ? x_adc_smc_i : x_smc_q;
        sum_rst_d  = (state_d == ST_CLEAR);
        sum_en_d   = (state_d == ST_STEP) && (cnt_d == '0);
        coeff_d    = (state_d == ST_STEP) ? rf_rd_c : '0;
        y_d        = (state_d == ST_DONE) ? loop_if.x_lin : y_q;
        srdyo_d    = (state_d == ST_DONE);
        busy_d     = (state_d != ST_IDLE);
        drop_d     = srdyi_i && (state_q inside {ST_CLEAR, ST_STEP, ST_DRAIN});
    end

    horner_seq_ctrl_coeff_rf #(
        .DEPTH  (DEGREE + 1),
        .DATA_W (COEFF_W),
        .ADDR_W (K_W)
    ) u_coeff_rf (
        .clk       (Clock),
        .rst       (GlobalReset),
        .wr_en_i   (coeff_we_c),
        .wr_addr_i (coeff_addr_i),
        .wr_data_i (coeff_data_i),
        .rd_addr_i (k_d),
        .rd_data_c (rf_rd_c)
    );

    always_ff @(posedge Clock) begin
        if (GlobalReset) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            cnt_q     <= '0;
            x_smc_q   <= '0;
            coeff_q   <= '0;
            sum_en_q  <= 1'b0;
            sum_rst_q <= 1'b0;
            y_q       <= '0;
            srdyo_q   <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            x_smc_q   <= x_smc_d;
            coeff_q   <= coeff_d;
            sum_en_q  <= sum_en_d;
            sum_rst_q <= sum_rst_d;
            y_q       <= y_d;
            srdyo_q   <= srdyo_d;
            busy_q    <= busy_d;
            drop_q    <= drop_d;
        end
    end

    assign loop_if.x_smc   = x_smc_q;
    assign loop_if.coeff   = coeff_q;
    assign loop_if.sum_en  = sum_en_q;
    assign loop_if.sum_rst = sum_rst_q;
    assign y_o             = y_q;
    assign srdyo_o         = srdyo_q;
    assign busy_o          = busy_q;
    assign drop_o          = drop_q;
endmodule
